// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port A between the load/store unit (0)
// and the debug loader (1); lane-aligns stores and routes load data back.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [1:0]  req0_size,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,
    output logic        resp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [1:0]  req1_size,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,
    output logic        resp1_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return ~off[0];
            2'd2:    return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] lane_shift(input logic [31:0] wdata, input logic [1:0] off);
        return wdata << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] dout, input logic [1:0] size,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        sh = dout >> {off, 3'b000};
        case (size)
            2'd0:    return {24'd0, sh[7:0]};
            2'd1:    return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic        last_grant;
    logic        gnt_p0, sel_p0, legal_p0, acc_p0, wr_p0;
    logic [1:0]  size_p0;
    logic [31:0] addr_p0, wdata_p0;

    logic        vld_p1, owner_p1, write_p1, err_p1;
    logic [1:0]  size_p1, off_p1;
    logic        rsp_vld_p1;
    logic [31:0] rdata_p1;

    // Stage p0: arbitration, legality check and memory command
    always_comb begin
        gnt_p0 = 1'b0;
        sel_p0 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                gnt_p0 = 1'b1;
                sel_p0 = ~last_grant;
            end else if (req0_valid) begin
                gnt_p0 = 1'b1;
            end else if (req1_valid) begin
                gnt_p0 = 1'b1;
                sel_p0 = 1'b1;
            end
        end
        wr_p0    = sel_p0 ? req1_write : req0_write;
        size_p0  = sel_p0 ? req1_size  : req0_size;
        addr_p0  = sel_p0 ? req1_addr  : req0_addr;
        wdata_p0 = sel_p0 ? req1_wdata : req0_wdata;
        legal_p0 = is_legal(size_p0, addr_p0[1:0]);
        acc_p0   = gnt_p0 & legal_p0;
        mem_en   = acc_p0;
        mem_we   = (acc_p0 && wr_p0) ? lane_mask(size_p0, addr_p0[1:0]) : 4'b0000;
        mem_addr = acc_p0 ? {addr_p0[31:2], 2'b00} : 32'd0;
        mem_din  = (acc_p0 && wr_p0) ? lane_shift(wdata_p0, addr_p0[1:0]) : 32'd0;
    end

    assign req0_ready = gnt_p0 & ~sel_p0;
    assign req1_ready = gnt_p0 &  sel_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            vld_p1 <= gnt_p0;
            if (gnt_p0)
                last_grant <= sel_p0;
        end
    end

    always_ff @(posedge clk) begin
        owner_p1 <= sel_p0;
        write_p1 <= wr_p0;
        size_p1  <= size_p0;
        off_p1   <= addr_p0[1:0];
        err_p1   <= ~legal_p0;
    end

    // Stage p1: memory data returns, decode and route to the owner
    always_comb begin
        rsp_vld_p1  = vld_p1 & ~reset;
        rdata_p1    = (write_p1 || err_p1) ? 32'd0 : lane_extract(mem_dout, size_p1, off_p1);
        resp0_valid = rsp_vld_p1 & ~owner_p1;
        resp1_valid = rsp_vld_p1 &  owner_p1;
        resp0_rdata = resp0_valid ? rdata_p1 : 32'd0;
        resp1_rdata = resp1_valid ? rdata_p1 : 32'd0;
        resp0_err   = resp0_valid & err_p1;
        resp1_err   = resp1_valid & err_p1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port memory
// and an independent arbitration/lane model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [1:0]  req0_size = 2'd0;
    logic [31:0] req0_addr = 32'd0, req0_wdata = 32'd0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [1:0]  req1_size = 2'd0;
    logic [31:0] req1_addr = 32'd0, req1_wdata = 32'd0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = 32'd0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    req_t        q0[$], q1[$];
    rsp_t        sb[$];
    logic        adv0 = 1'b0, adv1 = 1'b0;
    logic        m_last = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hA1B2C3D4;
        if (i == 17) return 32'h55667788;
        return 32'h01010101 * i + 32'h0F000000;
    endfunction

    // Behavioural memory: read data registered one cycle after enable
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_dout <= mem[mem_addr[7:2]];
                for (int j = 0; j < 4; j++)
                    if (mem_we[j]) mem[mem_addr[7:2]][8*j +: 8] <= mem_din[8*j +: 8];
            end
        end
    end

    // Requester drivers: present queue heads, retire after a modelled grant
    always @(posedge clk) begin
        req_t r;
        #1;
        if (adv0 && q0.size() != 0) r = q0.pop_front();
        if (adv1 && q1.size() != 0) r = q1.pop_front();
        adv0 = 1'b0;
        adv1 = 1'b0;
        if (q0.size() != 0) begin
            r = q0[0];
            req0_valid = 1'b1; req0_write = r.write; req0_size = r.size;
            req0_addr = r.addr; req0_wdata = r.wdata;
        end else begin
            req0_valid = 1'b0; req0_write = 1'b0; req0_size = 2'd0;
            req0_addr = 32'd0; req0_wdata = 32'd0;
        end
        if (q1.size() != 0) begin
            r = q1[0];
            req1_valid = 1'b1; req1_write = r.write; req1_size = r.size;
            req1_addr = r.addr; req1_wdata = r.wdata;
        end else begin
            req1_valid = 1'b0; req1_write = 1'b0; req1_size = 2'd0;
            req1_addr = 32'd0; req1_wdata = 32'd0;
        end
    end

    // Monitor on the falling edge: responses first, then this cycle's grant
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            logic        gnt, sel, legal, wr;
            logic [1:0]  sz;
            logic [31:0] ad, wd, w, exp_rd, exp_din, lane32;
            logic [3:0]  exp_we;
            int          off, nb;
            rsp_t        e;
            @(negedge clk);
            if (reset) begin
                sb.delete();
                chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
                chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
                chk("rst_resp0_rdata", resp0_rdata, 32'd0);
                chk("rst_resp1_rdata", resp1_rdata, 32'd0);
                chk("rst_resp_err", {30'd0, resp1_err, resp0_err}, 32'd0);
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_owner_valid", {30'd0, resp1_valid, resp0_valid},
                    e.owner ? 32'd2 : 32'd1);
                chk("resp_rdata", e.owner ? resp1_rdata : resp0_rdata, e.rdata);
                chk("resp_err", {31'd0, e.owner ? resp1_err : resp0_err}, {31'd0, e.err});
                chk("resp_other_quiet", e.owner ? (resp0_rdata | {31'd0, resp0_err})
                                                : (resp1_rdata | {31'd0, resp1_err}), 32'd0);
            end else begin
                chk("idle_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
                chk("idle_resp_rdata", resp0_rdata | resp1_rdata, 32'd0);
            end

            gnt = 1'b0;
            sel = 1'b0;
            if (reset) begin
                m_last = 1'b1;
            end else if (req0_valid && req1_valid) begin
                gnt = 1'b1; sel = (m_last == 1'b1) ? 1'b0 : 1'b1;
            end else if (req0_valid || req1_valid) begin
                gnt = 1'b1; sel = req1_valid;
            end
            chk("ready", {30'd0, req1_ready, req0_ready},
                gnt ? (sel ? 32'd2 : 32'd1) : 32'd0);
            if (!gnt) begin
                chk("nogrant_mem", {27'd0, mem_en, mem_we}, 32'd0);
                chk("nogrant_addr", mem_addr, 32'd0);
                chk("nogrant_din", mem_din, 32'd0);
            end else begin
                wr = sel ? req1_write : req0_write;
                sz = sel ? req1_size : req0_size;
                ad = sel ? req1_addr : req0_addr;
                wd = sel ? req1_wdata : req0_wdata;
                off = int'(ad[1:0]);
                legal = (sz == 2'd0) || (sz == 2'd1 && (off == 0 || off == 2)) ||
                        (sz == 2'd2 && off == 0);
                nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                exp_we = 4'b0000; exp_din = 32'd0; lane32 = 32'd0; exp_rd = 32'd0;
                if (legal) begin
                    for (int j = 0; j < 4; j++)
                        if (j >= off && j < off + nb) begin
                            exp_we[j] = wr;
                            lane32[8*j +: 8] = 8'hFF;
                            exp_din[8*j +: 8] = wd[8*(j-off) +: 8];
                        end
                    chk("grant_en", {31'd0, mem_en}, 32'd1);
                    chk("grant_addr", mem_addr, ad & 32'hFFFF_FFFC);
                    chk("grant_we", {28'd0, mem_we}, {28'd0, exp_we});
                    if (wr) begin
                        chk("grant_din", mem_din & lane32, exp_din);
                        for (int j = 0; j < 4; j++)
                            if (exp_we[j]) ref_mem[ad[7:2]][8*j +: 8] = exp_din[8*j +: 8];
                    end else begin
                        w = ref_mem[ad[7:2]];
                        for (int j = 0; j < nb; j++) exp_rd[8*j +: 8] = w[8*(off+j) +: 8];
                    end
                end else begin
                    chk("err_mem", {27'd0, mem_en, mem_we}, 32'd0);
                end
                e.owner = sel; e.rdata = exp_rd; e.err = ~legal;
                sb.push_back(e);
                m_last = sel;
                if (sel) adv1 = 1'b1; else adv0 = 1'b1;
            end
        end
    end

    function automatic req_t mk(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                                input logic [31:0] wd);
        req_t r;
        r.write = wr; r.size = sz; r.addr = ad; r.wdata = wd;
        return r;
    endfunction

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", q0.size() + q1.size(), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        q0.push_back(mk(1'b0, 2'd0, 32'h43, 32'd0));
        drain();

        q0.push_back(mk(1'b1, 2'd1, 32'h46, 32'h0000BEEF));
        q0.push_back(mk(1'b0, 2'd2, 32'h44, 32'd0));
        drain();

        q0.push_back(mk(1'b1, 2'd1, 32'h41, 32'hDEADDEAD));
        q0.push_back(mk(1'b0, 2'd2, 32'h42, 32'd0));
        q0.push_back(mk(1'b1, 2'd3, 32'h40, 32'hCAFEF00D));
        q0.push_back(mk(1'b0, 2'd2, 32'h40, 32'd0));
        drain();

        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 2'd2, 32'h40 + 32'(4*i), 32'd0));
            q1.push_back(mk(1'b1, 2'd2, 32'h50 + 32'(4*i), 32'h11110000 + 32'(i)));
        end
        drain();

        q1.push_back(mk(1'b1, 2'd2, 32'h60, 32'h12345678));
        q1.push_back(mk(1'b0, 2'd2, 32'h60, 32'd0));
        drain();

        q0.push_back(mk(1'b0, 2'd2, 32'h40, 32'd0));
        begin
            int n = 0;
            do begin
                @(posedge clk); #2;
                n++;
            end while (q0.size() != 0 && n < 50);
            chk("inflight_grant_seen", q0.size(), 32'd0);
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            repeat (3) @(posedge clk);
        end

        for (int i = 0; i < 20; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            32'h80 + 32'($urandom_range(0, 63)), $urandom));
            q1.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            32'h80 + 32'($urandom_range(0, 63)), $urandom));
        end
        drain();

        for (int i = 0; i < 64; i++) chk("mem_contents", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
